// File: rtl/adder_bist.sv
// Built-in self test for a 16-bit adder: LFSR operand generator,
// 2-cycle APPLY/CHECK per vector, saturating mismatch counter.
// Ports: clk, rst_n, start -> a, b, c_in to the adder; s, c_out back;
// status busy, done, pass, fail_count, vec_count.
// Optional first-failure capture (fail_a, fail_b, fail_cin, fail_sum)
// is enabled by defining ADDER_BIST_FAIL_CAPTURE_EN.
module adder_bist #(
  parameter int unsigned NUM_VEC = 64,
  parameter logic [15:0] SEED_A  = 16'hACE1,
  parameter logic [15:0] SEED_B  = 16'h1D2C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        c_in,
  input  logic [15:0] s,
  input  logic        c_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [7:0]  vec_count
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  ,
  output logic [15:0] fail_a,
  output logic [15:0] fail_b,
  output logic        fail_cin,
  output logic [16:0] fail_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] NV = 8'(NUM_VEC);

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] x
  );
    logic [15:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [15:0] lfsr_a;
  logic [15:0] lfsr_b;
  logic [15:0] nxt_a;
  logic [15:0] nxt_b;
  logic [16:0] exp_sum;
  logic [7:0]  vec_inc;
  logic        idle_or_done;
  logic        accept;
  logic        in_check;
  logic        mismatch;
  logic        last;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign accept   = start && idle_or_done;
  assign in_check = (state_q == CHECK);
  assign exp_sum  = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
  assign mismatch = in_check && ({c_out, s} != exp_sum);
  assign vec_inc  = vec_count + 8'd1;
  assign last     = (vec_inc == NV);
  assign nxt_a    = lfsr_step(lfsr_a);
  assign nxt_b    = lfsr_step(lfsr_b);

  assign busy = (state_q == APPLY) || in_check;
  assign done = (state_q == DONE);
  assign pass = done && (fail_count == 8'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = APPLY;
      APPLY: state_d = CHECK;
      CHECK: state_d = last ? DONE : APPLY;
      DONE:  if (start) state_d = APPLY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand outputs are separate from the LFSRs so they keep the
  // last applied vector once the LFSRs step past it into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a     <= SEED_A;
      lfsr_b     <= SEED_B;
      a          <= SEED_A;
      b          <= SEED_B;
      c_in       <= 1'b0;
      fail_count <= 8'd0;
      vec_count  <= 8'd0;
    end else if (accept) begin
      lfsr_a     <= SEED_A;
      lfsr_b     <= SEED_B;
      a          <= SEED_A;
      b          <= SEED_B;
      c_in       <= SEED_A[0] ^ SEED_B[15];
      fail_count <= 8'd0;
      vec_count  <= 8'd0;
    end else if (in_check) begin
      if (mismatch && fail_count != 8'hFF)
        fail_count <= fail_count + 8'd1;
      vec_count <= vec_inc;
      lfsr_a    <= nxt_a;
      lfsr_b    <= nxt_b;
      if (!last) begin
        a    <= nxt_a;
        b    <= nxt_b;
        c_in <= nxt_a[0] ^ nxt_b[15];
      end
    end
  end

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  // A zero fail_count marks the first mismatch of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a   <= 16'd0;
      fail_b   <= 16'd0;
      fail_cin <= 1'b0;
      fail_sum <= 17'd0;
    end else if (accept) begin
      fail_a   <= 16'd0;
      fail_b   <= 16'd0;
      fail_cin <= 1'b0;
      fail_sum <= 17'd0;
    end else if (mismatch && fail_count == 8'd0) begin
      fail_a   <= a;
      fail_b   <= b;
      fail_cin <= c_in;
      fail_sum <= {c_out, s};
    end
  end
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Directed self-checking bench for adder_bist: three instances
// (NUM_VEC 64, 1, 255) driving a behavioural adder with fault modes.
module tb_adder_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] a0, b0, s0, a1, b1, s1, a2, b2, s2;
  logic        cin0, cin1, cin2, co0, co1, co2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        pass0, pass1, pass2;
  logic [7:0]  fc0, fc1, fc2, vc0, vc1, vc2;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic [15:0] fa0, fb0, fa1, fb1, fa2, fb2;
  logic        fci0, fci1, fci2;
  logic [16:0] fs0, fs1, fs2;
`endif

  function automatic logic [16:0] dut_add(
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, input int m);
    logic [16:0] r;
    r = {1'b0, x} + {1'b0, y} + ((m == 2) ? 17'd0 : {16'd0, ci});
    if (m == 1) r[3] = 1'b0;
    return r;
  endfunction

  assign {co0, s0} = dut_add(a0, b0, cin0, mode);
  assign {co1, s1} = dut_add(a1, b1, cin1, mode);
  assign {co2, s2} = dut_add(a2, b2, cin2, mode);

  adder_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .a(a0), .b(b0), .c_in(cin0), .s(s0), .c_out(co0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .vec_count(vc0)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    , .fail_a(fa0), .fail_b(fb0), .fail_cin(fci0), .fail_sum(fs0)
`endif
  );

  adder_bist #(.NUM_VEC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c_in(cin1), .s(s1), .c_out(co1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .vec_count(vc1)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    , .fail_a(fa1), .fail_b(fb1), .fail_cin(fci1), .fail_sum(fs1)
`endif
  );

  adder_bist #(.NUM_VEC(255)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .c_in(cin2), .s(s2), .c_out(co2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .vec_count(vc2)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    , .fail_a(fa2), .fail_b(fb2), .fail_cin(fci2), .fail_sum(fs2)
`endif
  );

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Reference walk of the vector sequence under a fault mode.
  task automatic model_run(input int n, input int m, output int fails,
    output logic [15:0] fa, output logic [15:0] fb,
    output logic [15:0] la, output logic [15:0] lb);
    logic [15:0] x, y;
    logic ci;
    logic [16:0] good;
    x = 16'hACE1; y = 16'h1D2C;
    fails = 0; fa = 16'd0; fb = 16'd0;
    for (int i = 0; i < n; i++) begin
      ci = x[0] ^ y[15];
      good = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      if (dut_add(x, y, ci, m) != good) begin
        if (fails == 0) begin fa = x; fb = y; end
        fails++;
      end
      la = x; lb = y;
      x = step(x); y = step(y);
    end
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    case (w)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int w, output int cyc);
    logic d;
    cyc = 0;
    d = (w == 0) ? done0 : (w == 1) ? done1 : done2;
    while (!d && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      d = (w == 0) ? done0 : (w == 1) ? done1 : done2;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (a0 !== 16'hACE1 || b0 !== 16'h1D2C || cin0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ops got %h %h %b want ace1 1d2c 0", a0, b0, cin0);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 ||
        fc0 !== 8'd0 || vc0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_status got b%b d%b p%b f%0d v%0d want all 0",
               busy0, done0, pass0, fc0, vc0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_run;
    int cyc, f;
    logic [15:0] fa, fb, la, lb;
    mode = 0;
    model_run(64, 0, f, fa, fb, la, lb);
    pulse(0);
    checks++;
    if (busy0 !== 1'b1 || a0 !== 16'hACE1 || b0 !== 16'h1D2C ||
        cin0 !== 1'b1) begin
      errors++;
      $display("FAIL first_apply got b%b %h %h %b want 1 ace1 1d2c 1",
               busy0, a0, b0, cin0);
    end
    checks++;
    if ({co0, s0} !== 17'h0CA0E) begin
      errors++;
      $display("FAIL first_sum got %h want 0ca0e", {co0, s0});
    end
    wait_done(0, cyc);
    checks++;
    if (cyc != 128) begin
      errors++;
      $display("FAIL run_len got %0d want 128", cyc);
    end
    checks++;
    if (pass0 !== 1'b1 || fc0 !== 8'd0 || vc0 !== 8'd64 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL run_result got p%b f%0d v%0d b%b want 1 0 64 0",
               pass0, fc0, vc0, busy0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a0 !== la || b0 !== lb || done0 !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got %h %h d%b want %h %h 1", a0, b0, done0, la, lb);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    mode = 0;
    pulse(0);
    cyc = 0;
    while (!done0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start0 = (cyc == 10);
    end
    start0 = 1'b0;
    checks++;
    if (cyc != 128 || vc0 !== 8'd64 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignore got c%0d v%0d p%b want 128 64 1",
               cyc, vc0, pass0);
    end
  endtask

  task automatic test_stuck_bit;
    int cyc, f;
    logic [15:0] fa, fb, la, lb;
    mode = 1;
    model_run(64, 1, f, fa, fb, la, lb);
    pulse(0);
    wait_done(0, cyc);
    checks++;
    if (cyc != 128 || pass0 !== 1'b0 || int'(fc0) != f || fc0 == 8'd0) begin
      errors++;
      $display("FAIL stuck_s3 got c%0d p%b f%0d want 128 0 %0d", cyc, pass0, fc0, f);
    end
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    checks++;
    if (fa0 !== fa || fb0 !== fb) begin
      errors++;
      $display("FAIL capture got %h %h want %h %h", fa0, fb0, fa, fb);
    end
`endif
    mode = 0;
  endtask

  task automatic test_ignore_cin;
    int cyc, f;
    logic [15:0] fa, fb, la, lb;
    mode = 2;
    model_run(255, 2, f, fa, fb, la, lb);
    pulse(2);
    wait_done(2, cyc);
    checks++;
    if (cyc != 510 || vc2 !== 8'd255 || int'(fc2) != f || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_cin got c%0d v%0d f%0d want 510 255 %0d",
               cyc, vc2, fc2, f);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid;
    mode = 0;
    pulse(0);
    repeat (39) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || vc0 !== 8'd19) begin
      errors++;
      $display("FAIL mid_state got b%b v%0d want 1 19", busy0, vc0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 ||
        vc0 !== 8'd0 || fc0 !== 8'd0 || a0 !== 16'hACE1 ||
        b0 !== 16'h1D2C || cin0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got b%b d%b v%0d %h %h %b want reset values",
               busy0, done0, vc0, a0, b0, cin0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse(0);
    checks++;
    if (busy0 !== 1'b1 || a0 !== 16'hACE1 || b0 !== 16'h1D2C || cin0 !== 1'b1) begin
      errors++;
      $display("FAIL replay got b%b %h %h %b want 1 ace1 1d2c 1",
               busy0, a0, b0, cin0);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    pulse(1);
    wait_done(1, cyc);
    checks++;
    if (cyc != 2 || vc1 !== 8'd1 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL nv1_run got c%0d v%0d p%b want 2 1 1", cyc, vc1, pass1);
    end
    pulse(1);
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || a1 !== 16'hACE1 || b1 !== 16'h1D2C) begin
      errors++;
      $display("FAIL nv1_rerun got b%b d%b %h %h want 1 0 ace1 1d2c",
               busy1, done1, a1, b1);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 2 || vc1 !== 8'd1) begin
      errors++;
      $display("FAIL nv1_rerun_len got c%0d v%0d want 2 1", cyc, vc1);
    end
  endtask

  initial begin
    test_reset();
    test_first_run();
    test_start_ignored();
    test_stuck_bit();
    test_ignore_cin();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
